// File: rtl/neurotransmitter_controller.sv
`default_nettype none
// ============================================================================
// Module      : neurotransmitter_controller
// Description : Keeps one saturating level register for each of CORT, DOP,
//               GABA, NE and SER. On every time-base tick the levels move
//               with the active stimuli and the sleep state, and periodically
//               decay one step toward BASELINE. The top two bits of each level
//               are published, packed, for the emotion regulator.
//
// Ports:
//   clk                     system clock
//   rst                     synchronous active-high reset
//   tick                    one-cycle time-base strobe; updates happen only here
//   action[7:0]             bit0 = asleep, other bits ignored
//   stimuli[15:0]           stimulus flags
//                             [0] fed  [1] played  [2] petted  [3] loud
//                             [4] scolded  [9] lonely  [10] praised
//                             [11] hungry  [12] starving  [13] tired
//                             [14] sick  [15] pain  ([8:5] reserved)
//   development_stage[1:0]  0 = baby (double step), 1..3 = normal step
//   neurotransmitter_level  packed 2-bit levels:
//                             [1:0] CORT [3:2] DOP [5:4] GABA [7:6] NE [9:8] SER
//   level_updated           one-cycle pulse in the cycle after a tick applied
//
// Revision    : 1.0 - initial release
// ============================================================================
module neurotransmitter_controller #(
    parameter int LEVEL_WIDTH  = 6,
    parameter int BASELINE     = 24,
    parameter int STEP         = 4,
    parameter int DECAY_PERIOD = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [7:0]  action,
    input  logic [15:0] stimuli,
    input  logic [1:0]  development_stage,
    output logic [9:0]  neurotransmitter_level,
    output logic        level_updated
);

    // Three guard bits: one sign bit plus headroom for the summed deltas.
    localparam int c_SUM_W = LEVEL_WIDTH + 3;
    localparam int c_CNT_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam int c_NUM   = 5;

    localparam int c_CORT = 0;
    localparam int c_DOP  = 1;
    localparam int c_GABA = 2;
    localparam int c_NE   = 3;
    localparam int c_SER  = 4;

    localparam logic [LEVEL_WIDTH-1:0]    c_BASE     = LEVEL_WIDTH'(BASELINE);
    localparam logic signed [c_SUM_W-1:0] c_MAX      = c_SUM_W'((1 << LEVEL_WIDTH) - 1);
    localparam logic signed [c_SUM_W-1:0] c_ONE      = c_SUM_W'(1);
    localparam logic [c_CNT_W-1:0]        c_CNT_LAST = c_CNT_W'(DECAY_PERIOD - 1);

    logic [LEVEL_WIDTH-1:0] r_level [c_NUM];
    logic [c_CNT_W-1:0]     r_decay_cnt;
    logic                   r_level_updated;

    logic [LEVEL_WIDTH-1:0]    w_next  [c_NUM];
    logic signed [c_SUM_W-1:0] w_delta [c_NUM];
    logic signed [c_SUM_W-1:0] w_step;
    logic                      w_decay_now;
    logic                      w_asleep;
    logic                      w_unused;

    // Named stimulus flags
    logic w_fed, w_played, w_petted, w_loud, w_scolded, w_lonely, w_praised;
    logic w_hungry, w_starving, w_tired, w_sick, w_pain;

    assign w_fed      = stimuli[0];
    assign w_played   = stimuli[1];
    assign w_petted   = stimuli[2];
    assign w_loud     = stimuli[3];
    assign w_scolded  = stimuli[4];
    assign w_lonely   = stimuli[9];
    assign w_praised  = stimuli[10];
    assign w_hungry   = stimuli[11];
    assign w_starving = stimuli[12];
    assign w_tired    = stimuli[13];
    assign w_sick     = stimuli[14];
    assign w_pain     = stimuli[15];
    assign w_asleep   = action[0];

    // Reserved stimulus bits and the non-sleep action bits carry no meaning here.
    assign w_unused = ^{action[7:1], stimuli[8:5]};

    function automatic logic signed [c_SUM_W-1:0] f_term(
        input logic                      flag,
        input logic signed [c_SUM_W-1:0] amount
    );
        return flag ? amount : '0;
    endfunction

    assign w_step      = (development_stage == 2'd0) ? c_SUM_W'(STEP * 2) : c_SUM_W'(STEP);
    assign w_decay_now = (r_decay_cnt == c_CNT_LAST);

    // Stimulus and sleep contributions, summed together per level.
    assign w_delta[c_DOP]  = f_term(w_fed, w_step) + f_term(w_played, w_step)
                           + f_term(w_praised, w_step)
                           - f_term(w_hungry, w_step) - f_term(w_sick, w_step);

    assign w_delta[c_SER]  = f_term(w_fed, w_step) + f_term(w_petted, w_step)
                           + f_term(w_praised, w_step)
                           - f_term(w_lonely, w_step) - f_term(w_starving, w_step)
                           + f_term(w_asleep, c_ONE);

    assign w_delta[c_GABA] = f_term(w_petted, w_step)
                           - f_term(w_loud, w_step) - f_term(w_pain, w_step)
                           + f_term(w_asleep, c_ONE);

    assign w_delta[c_NE]   = f_term(w_loud, w_step) + f_term(w_scolded, w_step)
                           + f_term(w_played, w_step)
                           - f_term(w_tired, w_step)
                           - f_term(w_asleep, w_step);

    assign w_delta[c_CORT] = f_term(w_scolded, w_step) + f_term(w_starving, w_step)
                           + f_term(w_pain, w_step) + f_term(w_sick, w_step)
                           - f_term(w_petted, w_step)
                           - f_term(w_asleep, w_step);

    // Per-level decay toward baseline and saturation into the register range.
    genvar gi;
    generate
        for (gi = 0; gi < c_NUM; gi++) begin : g_level
            logic signed [c_SUM_W-1:0] w_decay;
            logic signed [c_SUM_W-1:0] w_sum;

            // Decay direction is judged on the level before this tick's update.
            assign w_decay = !w_decay_now              ? '0 :
                             (r_level[gi] > c_BASE)    ? -c_ONE :
                             (r_level[gi] < c_BASE)    ? c_ONE :
                                                         '0;

            assign w_sum = $signed({3'b000, r_level[gi]}) + w_delta[gi] + w_decay;

            assign w_next[gi] = (w_sum < 0)     ? '0 :
                                (w_sum > c_MAX) ? '1 :
                                                  w_sum[LEVEL_WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NUM; i++) begin
                r_level[i] <= c_BASE;
            end
            r_decay_cnt     <= '0;
            r_level_updated <= 1'b0;
        end else begin
            r_level_updated <= tick;
            if (tick) begin
                for (int i = 0; i < c_NUM; i++) begin
                    r_level[i] <= w_next[i];
                end
                r_decay_cnt <= w_decay_now ? '0 : r_decay_cnt + c_CNT_W'(1);
            end
        end
    end

    // Quantised view: top two bits of each level register.
    assign neurotransmitter_level = {
        r_level[c_SER] [LEVEL_WIDTH-1:LEVEL_WIDTH-2],
        r_level[c_NE]  [LEVEL_WIDTH-1:LEVEL_WIDTH-2],
        r_level[c_GABA][LEVEL_WIDTH-1:LEVEL_WIDTH-2],
        r_level[c_DOP] [LEVEL_WIDTH-1:LEVEL_WIDTH-2],
        r_level[c_CORT][LEVEL_WIDTH-1:LEVEL_WIDTH-2]
    };

    assign level_updated = r_level_updated;

endmodule
`default_nettype wire

// File: tb/tb_neurotransmitter_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_neurotransmitter_controller
// Description : Directed self-checking bench for neurotransmitter_controller.
//               Expected packed levels are hand-derived with default
//               parameters (LEVEL_WIDTH=6, BASELINE=24, STEP=4, DECAY_PERIOD=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neurotransmitter_controller;

    logic        clk;
    logic        rst;
    logic        tick;
    logic [7:0]  action;
    logic [15:0] stimuli;
    logic [1:0]  development_stage;
    logic [9:0]  neurotransmitter_level;
    logic        level_updated;

    int checks;
    int failures;

    neurotransmitter_controller dut (
        .clk                    (clk),
        .rst                    (rst),
        .tick                   (tick),
        .action                 (action),
        .stimuli                (stimuli),
        .development_stage      (development_stage),
        .neurotransmitter_level (neurotransmitter_level),
        .level_updated          (level_updated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One tick cycle; outputs are sampled 1 time unit after the edge.
    task automatic do_tick(input logic [15:0] s, input logic [7:0] a, input logic [1:0] st);
        stimuli           = s;
        action            = a;
        development_stage = st;
        tick              = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    // Reset with a simultaneous tick, which must be discarded.
    task automatic do_reset();
        rst     = 1'b1;
        tick    = 1'b1;
        stimuli = 16'h0008;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        tick    = 1'b0;
        stimuli = 16'h0000;
        action  = 8'h00;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        rst               = 1'b1;
        tick              = 1'b1;
        action            = 8'h00;
        stimuli           = 16'h0008;
        development_stage = 2'd1;

        // ---- Reset for two cycles, tick asserted alongside ----
        idle_cycle();
        idle_cycle();
        check("reset_level", neurotransmitter_level, 10'h155);
        check("reset_upd", {9'd0, level_updated}, 10'd0);
        rst     = 1'b0;
        tick    = 1'b0;
        stimuli = 16'h0000;
        idle_cycle();
        check("post_reset_level", neurotransmitter_level, 10'h155);
        check("post_reset_upd", {9'd0, level_updated}, 10'd0);

        // ---- Loud, stage 1, three back-to-back ticks ----
        do_tick(16'h0008, 8'h00, 2'd1);
        check("loud_t1", neurotransmitter_level, 10'h155);   // NE 28, GABA 20
        check("loud_t1_upd", {9'd0, level_updated}, 10'd1);
        do_tick(16'h0008, 8'h00, 2'd1);
        check("loud_t2", neurotransmitter_level, 10'h195);   // NE 32, GABA 16
        check("loud_t2_upd", {9'd0, level_updated}, 10'd1);
        do_tick(16'h0008, 8'h00, 2'd1);
        check("loud_t3", neurotransmitter_level, 10'h185);   // NE 36, GABA 12
        idle_cycle();
        check("loud_upd_drop", {9'd0, level_updated}, 10'd0);
        check("loud_hold", neurotransmitter_level, 10'h185);

        // ---- Five more ticks with only reserved bits set; 8th tick decays ----
        for (int i = 0; i < 5; i++) begin
            do_tick(16'h01E0, 8'h00, 2'd1);
        end
        check("decay_t8", neurotransmitter_level, 10'h185);  // NE 35, GABA 13

        // ---- tick low: random inputs must not disturb anything ----
        for (int i = 0; i < 50; i++) begin
            stimuli           = 16'($urandom);
            action            = 8'($urandom);
            development_stage = 2'($urandom_range(0, 3));
            idle_cycle();
            check("hold_level", neurotransmitter_level, 10'h185);
            check("hold_upd", {9'd0, level_updated}, 10'd0);
        end

        // Three more ticks put the decay counter mid-period before reset.
        for (int i = 0; i < 3; i++) begin
            do_tick(16'h0000, 8'h00, 2'd1);
        end
        check("pre_midreset", neurotransmitter_level, 10'h185);
        do_reset();
        check("midreset_level", neurotransmitter_level, 10'h155);
        check("midreset_upd", {9'd0, level_updated}, 10'd0);

        // ---- Decay counter restarts: decay becomes visible only on tick 8 ----
        do_tick(16'h000A, 8'h01, 2'd2);   // loud+played, asleep
        check("dec_t1", neurotransmitter_level, 10'h155);
        do_tick(16'h000A, 8'h01, 2'd2);
        check("dec_t2", neurotransmitter_level, 10'h199);
        do_tick(16'h200A, 8'h01, 2'd2);   // + tired
        check("dec_t3", neurotransmitter_level, 10'h188);   // C12 D36 G15 N32 S27
        for (int i = 0; i < 4; i++) begin
            do_tick(16'h0000, 8'h00, 2'd2);
        end
        check("dec_t7", neurotransmitter_level, 10'h188);
        do_tick(16'h0000, 8'h00, 2'd2);
        check("dec_t8", neurotransmitter_level, 10'h158);   // C13 D35 G16 N31 S26

        // ---- Stage 0 scolded: CORT and NE saturate at 63 ----
        do_reset();
        do_tick(16'h0010, 8'h00, 2'd0);
        check("scold_t1", neurotransmitter_level, 10'h196);
        do_tick(16'h0010, 8'h00, 2'd0);
        do_tick(16'h0010, 8'h00, 2'd0);
        check("scold_t3", neurotransmitter_level, 10'h1D7);
        do_tick(16'h0010, 8'h00, 2'd0);
        do_tick(16'h0010, 8'h00, 2'd0);
        check("scold_t5_clamp", neurotransmitter_level, 10'h1D7);
        for (int i = 0; i < 5; i++) begin
            do_tick(16'h0010, 8'h00, 2'd0);
        end
        check("scold_t10_clamp", neurotransmitter_level, 10'h1D7);

        // ---- Asleep, no stimuli: NE/CORT fall to 0, GABA/SER creep up ----
        do_reset();
        do_tick(16'h0000, 8'h01, 2'd3);
        check("sleep_t1", neurotransmitter_level, 10'h155);
        for (int i = 0; i < 3; i++) begin
            do_tick(16'h0000, 8'h01, 2'd3);
        end
        check("sleep_t4", neurotransmitter_level, 10'h114);  // N=C=8, G=S=28
        for (int i = 0; i < 4; i++) begin
            do_tick(16'h0000, 8'h01, 2'd3);
        end
        check("sleep_t8_floor", neurotransmitter_level, 10'h114);  // N=C=0, G=S=31
        do_tick(16'h0000, 8'h01, 2'd3);
        check("sleep_t9", neurotransmitter_level, 10'h224);  // G=S=32

        // ---- Single stage-0 ticks exercising the remaining flag mapping ----
        do_reset();
        do_tick(16'h0401, 8'h00, 2'd0);   // fed + praised
        check("map_fed_praised", neurotransmitter_level, 10'h259);
        do_reset();
        do_tick(16'h5A00, 8'h00, 2'd0);   // lonely, hungry, starving, sick
        check("map_negatives", neurotransmitter_level, 10'h052);
        do_reset();
        do_tick(16'h8004, 8'h00, 2'd0);   // petted + pain
        check("map_petted_pain", neurotransmitter_level, 10'h255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/neurotransmitter_controller.md
Name: neurotransmitter_controller

Overview:
- Sequential stage directly upstream of the emotion regulator.
- Holds one saturating level register per neurotransmitter: CORT, DOP, GABA, NE and SER.
- On each slow time-base tick, it raises or lowers the levels from the stimuli and sleep state, and decays them toward a baseline.
- It publishes the packed 2-bit quantised levels on neurotransmitter_level, which the emotion regulator consumes.

Parameters:
LEVEL_WIDTH, 6, width of each internal level register (range 0..2^LEVEL_WIDTH-1)
BASELINE, 24, reset value of each level and the decay target
STEP, 4, per-tick increment/decrement per active stimulus (doubled at development_stage 0)
DECAY_PERIOD, 8, number of ticks between decay steps (>=1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
tick  input  1  one-cycle time-base strobe; updates occur only on cycles with tick=1
action  input  8  current action; bit0 = asleep, other bits ignored
stimuli  input  16  stimulus flags (bit map in Behaviour)
development_stage  input  2  0 = baby (step doubled), 1..3 = normal step
neurotransmitter_level  output  10  packed quantised levels: [1:0] CORT, [3:2] DOP, [5:4] GABA, [7:6] NE, [9:8] SER
level_updated  output  1  one-cycle pulse in the cycle after a tick was applied

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high on clk.
  - Reset has priority over tick.
- Reset state:
  - All five levels = BASELINE.
  - Decay counter = 0.
  - level_updated = 0.
  - neurotransmitter_level = each level[LW-1:LW-2]; with defaults this is 10'h155 (all 01).
- Output quantisation:
  - Each 2-bit field = top two bits of its level register.
  - Fields are purely registered; no combinational path from inputs.
- Stimuli bit map:
  - [0] fed, [1] played, [2] petted, [3] loud, [4] scolded, [9] lonely, [10] praised
  - [11] hungry, [12] starving, [13] tired, [14] sick, [15] pain
  - [5]..[8] reserved; they have no effect.
- Effective step: S = STEP<<1 when development_stage==0, else STEP.
- Per-tick stimulus delta (each active flag contributes +S or -S):
  - DOP: +fed, +played, +praised; -hungry, -sick
  - SER: +fed, +petted, +praised; -lonely, -starving
  - GABA: +petted; -loud, -pain
  - NE: +loud, +scolded, +played; -tired
  - CORT: +scolded, +starving, +pain, +sick; -petted
- Sleep term (action[0]=1), per tick:
  - NE and CORT: additional -S.
  - GABA and SER: additional +1.
- Decay:
  - The decay counter increments on every applied tick and wraps at DECAY_PERIOD-1 to 0.
  - On the tick where the counter equals DECAY_PERIOD-1, each level gets an additional -1 if it is above BASELINE, +1 if below, 0 if equal.
  - The comparison uses the pre-update level.
- Arithmetic:
  - new = level + stimulus delta + sleep term + decay term.
  - Compute in signed LEVEL_WIDTH+3 bits.
  - Clamp to [0, 2^LEVEL_WIDTH-1]; no wrap-around under any combination.
  - All contributions are summed simultaneously; no ordering between them.
- Latency:
  - Levels and outputs update at the clk edge that samples tick=1; new values are visible the following cycle.
  - level_updated = 1 in exactly that following cycle, then 0.
- tick=0: levels, counter and outputs hold regardless of stimuli, action or development_stage.
- Back-to-back ticks (tick high on consecutive cycles): each cycle is an independent update; level_updated stays high continuously.
- Reset mid-operation: all state returns to reset values on the next edge, including the decay counter; any tick in the same cycle is discarded.

Test Plan:
1. Assert rst for 2 cycles -> neurotransmitter_level=10'h155 and level_updated=0; tick together with rst -> no update.
2. Stage 1, stimuli[3]=1 (loud) held for 3 ticks -> NE 24→36 (field 10), GABA 24→12 (field 00), others 01; level_updated pulses once per tick.
3. Continue from 2 with stimuli=0 for 5 more ticks (the 8th tick is a decay tick) -> NE=35, GABA=13; fields NE=10, GABA=00.
4. Stage 0, stimuli[4]=1 (scolded) held for 10 ticks -> CORT clamps at 63 (field 11) with no wrap; NE also clamps at 63.
5. action[0]=1 (asleep), stimuli=0, 4 ticks from reset -> NE=CORT=8 (field 00), GABA=SER=28 (field 01); continuing to clamp -> NE=CORT=0, never negative.
6. tick=0 for 50 cycles with random stimuli/action -> outputs unchanged; then assert rst mid-sequence after test 2 -> 10'h155, and the decay counter restarts (decay first occurs on the 8th subsequent tick).
